// File: rtl/sram_pkg.sv
// Shared constants, state encoding and phase-length helpers for the SRAM
// read/write sequencers.
package sram_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] ADDR_IDLE = 9'h1FF;
  localparam logic [DATA_W-1:0] DATA_IDLE = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACTIVE  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  // A zero phase unit would collapse the timeline, so it behaves as one tick.
  function automatic logic [7:0] clamp_k(input logic [7:0] k);
    return (k == 8'd0) ? 8'd1 : k;
  endfunction

  function automatic logic [7:0] clamp_h(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Tick counter for SRAM cycle phases; flags the counts at which the next
// phase transition must be registered.
module sram_phase_counter
  import sram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] kq,
  input  logic [7:0] hq,
  output logic       hit_one,
  output logic       hit_half,
  output logic       hit_close,
  output logic       hit_end
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] k_ext;
  logic [CNT_W-1:0] h_ext;

  always_comb begin
    k_ext = {8'd0, kq};
    h_ext = {8'd0, hq};
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Thresholds peak at 4*255+255-1, well inside the counter range.
  always_comb begin
    hit_one   = (cnt_q == CNT_W'(1));
    hit_half  = (cnt_q == (k_ext << 1));
    hit_close = (cnt_q == ((k_ext << 2) - CNT_W'(1)));
    hit_end   = (cnt_q == ((k_ext << 2) + h_ext - CNT_W'(1)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_write_cycle.sv
// One timed SRAM write cycle per start pulse; all pins are registered.
// Optional multi-word burst is enabled by defining SRAM_WRITE_BURST_EN.
module sram_write_cycle
  import sram_pkg::*;
(
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              start_in,
  input  logic [7:0]        clk_factor,
  input  logic [7:0]        hold_delay,
  input  logic [ADDR_W-1:0] a_in,
  input  logic [DATA_W-1:0] d_in,
`ifdef SRAM_WRITE_BURST_EN
  input  logic [ADDR_W-1:0] burst_len_in,
  output logic              d_req,
`endif
  output logic              clk_out,
  output logic              cen_out,
  output logic              wen_out,
  output logic [ADDR_W-1:0] a_out,
  output logic [DATA_W-1:0] d_out,
  output logic              d_oe,
  output logic              writing,
  output logic              done
);

  state_e            state_q, state_d;
  logic              start_r_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        kq_q, kq_d;
  logic [7:0]        hq_q, hq_d;
  logic              clk_out_q, clk_out_d;
  logic              cen_q, cen_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] a_out_q, a_out_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_oe_q, d_oe_d;
  logic              writing_q, writing_d;
  logic              done_q, done_d;
`ifdef SRAM_WRITE_BURST_EN
  logic [ADDR_W-1:0] words_left_q, words_left_d;
  logic              relaunch_q, relaunch_d;
  logic              d_req_q, d_req_d;
`endif

  logic cnt_clr;
  logic cnt_en;
  logic hit_one;
  logic hit_half;
  logic hit_close;
  logic hit_end;

  sram_phase_counter u_phase_counter (
    .clk       (clk_in),
    .rst_n     (reset_in),
    .clr       (cnt_clr),
    .en        (cnt_en),
    .kq        (kq_q),
    .hq        (hq_q),
    .hit_one   (hit_one),
    .hit_half  (hit_half),
    .hit_close (hit_close),
    .hit_end   (hit_end)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    kq_d      = kq_q;
    hq_d      = hq_q;
    clk_out_d = clk_out_q;
    cen_d     = cen_q;
    wen_d     = wen_q;
    a_out_d   = a_out_q;
    d_out_d   = d_out_q;
    d_oe_d    = d_oe_q;
    writing_d = writing_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
`ifdef SRAM_WRITE_BURST_EN
    words_left_d = words_left_q;
    relaunch_d   = 1'b0;
    d_req_d      = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start_r_q) begin
          // Acceptance edge: the counter reads 1 afterwards so each
          // threshold compare fires one tick before its phase edge.
          cnt_clr   = 1'b0;
          cnt_en    = 1'b1;
          state_d   = ST_ACTIVE;
          addr_d    = a_in;
          data_d    = d_in;
          kq_d      = clamp_k(clk_factor);
          hq_d      = clamp_h(hold_delay);
          clk_out_d = 1'b0;
          writing_d = 1'b1;
`ifdef SRAM_WRITE_BURST_EN
          words_left_d = burst_len_in;
`endif
        end
      end

      ST_ACTIVE: begin
        cnt_en = 1'b1;
`ifdef SRAM_WRITE_BURST_EN
        if (relaunch_q) begin
          data_d    = d_in;
          clk_out_d = 1'b0;
        end
`endif
        if (hit_one) begin
          cen_d   = 1'b0;
          wen_d   = 1'b0;
          a_out_d = addr_q;
          d_out_d = data_q;
          d_oe_d  = 1'b1;
        end
        if (hit_half) begin
          clk_out_d = 1'b1;
        end
        if (hit_close) begin
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          state_d = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        cnt_en = 1'b1;
        if (hit_end) begin
          cnt_clr   = 1'b1;
          d_oe_d    = 1'b0;
          a_out_d   = ADDR_IDLE;
          d_out_d   = DATA_IDLE;
          writing_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
`ifdef SRAM_WRITE_BURST_EN
          if (words_left_q != '0) begin
            // Counter restarts at 0; the next edge acts as the word's E1.
            words_left_d = words_left_q - 1'b1;
            addr_d       = addr_q + 1'b1;
            d_req_d      = 1'b1;
            relaunch_d   = 1'b1;
            writing_d    = 1'b1;
            done_d       = 1'b0;
            state_d      = ST_ACTIVE;
          end
`endif
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q   <= ST_IDLE;
      start_r_q <= 1'b0;
      addr_q    <= ADDR_IDLE;
      data_q    <= DATA_IDLE;
      kq_q      <= 8'd1;
      hq_q      <= 8'd1;
      clk_out_q <= 1'b1;
      cen_q     <= 1'b1;
      wen_q     <= 1'b1;
      a_out_q   <= ADDR_IDLE;
      d_out_q   <= DATA_IDLE;
      d_oe_q    <= 1'b0;
      writing_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef SRAM_WRITE_BURST_EN
      words_left_q <= '0;
      relaunch_q   <= 1'b0;
      d_req_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      start_r_q <= start_in;
      addr_q    <= addr_d;
      data_q    <= data_d;
      kq_q      <= kq_d;
      hq_q      <= hq_d;
      clk_out_q <= clk_out_d;
      cen_q     <= cen_d;
      wen_q     <= wen_d;
      a_out_q   <= a_out_d;
      d_out_q   <= d_out_d;
      d_oe_q    <= d_oe_d;
      writing_q <= writing_d;
      done_q    <= done_d;
`ifdef SRAM_WRITE_BURST_EN
      words_left_q <= words_left_d;
      relaunch_q   <= relaunch_d;
      d_req_q      <= d_req_d;
`endif
    end
  end

  assign clk_out = clk_out_q;
  assign cen_out = cen_q;
  assign wen_out = wen_q;
  assign a_out   = a_out_q;
  assign d_out   = d_out_q;
  assign d_oe    = d_oe_q;
  assign writing = writing_q;
  assign done    = done_q;
`ifdef SRAM_WRITE_BURST_EN
  assign d_req   = d_req_q;
`endif

endmodule

// File: tb/tb_sram_write_cycle.sv
// Directed bench for sram_write_cycle: edge-by-edge pin checks against a
// hand-written timeline of the write cycle.
module tb_sram_write_cycle;
  import sram_pkg::*;

  logic              clk_in = 1'b0;
  logic              reset_in;
  logic              start_in;
  logic [7:0]        clk_factor;
  logic [7:0]        hold_delay;
  logic [ADDR_W-1:0] a_in;
  logic [DATA_W-1:0] d_in;
  logic              clk_out;
  logic              cen_out;
  logic              wen_out;
  logic [ADDR_W-1:0] a_out;
  logic [DATA_W-1:0] d_out;
  logic              d_oe;
  logic              writing;
  logic              done;
`ifdef SRAM_WRITE_BURST_EN
  logic [ADDR_W-1:0] burst_len_in;
  logic              d_req;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [22:0] IDLE_PINS = {6'b111000, 9'h1FF, 8'hFF};

  always #5 clk_in = ~clk_in;

  sram_write_cycle dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .start_in     (start_in),
    .clk_factor   (clk_factor),
    .hold_delay   (hold_delay),
    .a_in         (a_in),
    .d_in         (d_in),
`ifdef SRAM_WRITE_BURST_EN
    .burst_len_in (burst_len_in),
    .d_req        (d_req),
`endif
    .clk_out      (clk_out),
    .cen_out      (cen_out),
    .wen_out      (wen_out),
    .a_out        (a_out),
    .d_out        (d_out),
    .d_oe         (d_oe),
    .writing      (writing),
    .done         (done)
  );

  logic [22:0] obs_pins;
  assign obs_pins = {clk_out, cen_out, wen_out, d_oe, writing, done, a_out, d_out};

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected pins after edge En of a single-word cycle whose start_in was at E0.
  function automatic logic [22:0] exp_pins(input int n, input int k, input int h,
                                           input logic [8:0] a, input logic [7:0] d);
    int   kq;
    int   hq;
    logic c;
    logic ce;
    logic bus;
    logic wr;
    logic dn;
    kq  = (k == 0) ? 1 : k;
    hq  = (h == 0) ? 1 : h;
    c   = !(n >= 1 && n < 1 + 2 * kq);
    ce  = !(n >= 2 && n < 4 * kq);
    bus = (n >= 2 && n < 4 * kq + hq);
    wr  = (n >= 1 && n < 4 * kq + hq);
    dn  = (n == 4 * kq + hq);
    return {c, ce, ce, bus, wr, dn, bus ? a : 9'h1FF, bus ? d : 8'hFF};
  endfunction

  // Present operands and pulse start_in for one tick; returns just after E0.
  task automatic start_cycle(input logic [7:0] k, input logic [7:0] h,
                             input logic [8:0] a, input logic [7:0] d);
    clk_factor = k;
    hold_delay = h;
    a_in       = a;
    d_in       = d;
    start_in   = 1'b1;
    tick();
    start_in   = 1'b0;
  endtask

  initial begin
    int wr_cnt;
    int done_cnt;
    reset_in   = 1'b0;
    start_in   = 1'b0;
    clk_factor = 8'd1;
    hold_delay = 8'd1;
    a_in       = '0;
    d_in       = '0;
`ifdef SRAM_WRITE_BURST_EN
    burst_len_in = '0;
`endif

    // Reset state
    tick();
    tick();
    check("reset_pins", obs_pins, IDLE_PINS);
    reset_in = 1'b1;
    tick();
    check("post_reset_idle", obs_pins, IDLE_PINS);

    // Basic write K=2 H=3; operands and K change after E3 must not matter
    start_cycle(8'd2, 8'd3, 9'h0A5, 8'h3C);
    check("basic_e0", obs_pins, IDLE_PINS);
    wr_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check($sformatf("basic_e%0d", n), obs_pins, exp_pins(n, 2, 3, 9'h0A5, 8'h3C));
      if (writing) wr_cnt++;
      if (n == 3) begin
        a_in       = 9'h155;
        d_in       = 8'hC3;
        clk_factor = 8'd7;
        hold_delay = 8'd9;
      end
    end
    check("basic_writing_ticks", wr_cnt, 10);

    // Clamp: K=0 H=0 behaves as K=1 H=1, done at E5
    start_cycle(8'd0, 8'd0, 9'h003, 8'h81);
    for (int n = 1; n <= 6; n++) begin
      tick();
      check($sformatf("clamp_e%0d", n), obs_pins, exp_pins(n, 0, 0, 9'h003, 8'h81));
    end

    // Start while busy (at E4) and start on the done edge are both ignored
    start_cycle(8'd2, 8'd3, 9'h10F, 8'h5A);
    done_cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check($sformatf("busy_e%0d", n), obs_pins, exp_pins(n, 2, 3, 9'h10F, 8'h5A));
      if (done) done_cnt++;
      start_in = (n == 3) || (n == 9);
    end
    check("busy_done_count", done_cnt, 1);

    // Start two ticks after done begins a fresh cycle (K=1 H=2, done at E6)
    start_cycle(8'd1, 8'd2, 9'h0F0, 8'h0F);
    check("restart_e0", obs_pins, IDLE_PINS);
    for (int n = 1; n <= 7; n++) begin
      tick();
      check($sformatf("restart_e%0d", n), obs_pins, exp_pins(n, 1, 2, 9'h0F0, 8'h0F));
    end

    // Reset at E6 aborts the cycle with no done pulse
    start_cycle(8'd2, 8'd3, 9'h1AA, 8'h99);
    for (int n = 1; n <= 5; n++) begin
      tick();
      check($sformatf("abort_e%0d", n), obs_pins, exp_pins(n, 2, 3, 9'h1AA, 8'h99));
    end
    reset_in = 1'b0;
    tick();
    check("abort_reset_edge", obs_pins, IDLE_PINS);
    reset_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("abort_quiet_%0d", i), obs_pins, IDLE_PINS);
    end
    start_cycle(8'd1, 8'd2, 9'h055, 8'hE7);
    for (int n = 1; n <= 7; n++) begin
      tick();
      check($sformatf("after_abort_e%0d", n), obs_pins, exp_pins(n, 1, 2, 9'h055, 8'hE7));
    end

`ifdef SRAM_WRITE_BURST_EN
    // Burst of three words from 0x1FE with address wrap
    begin
      logic [8:0] exp_a [3];
      int req_cnt;
      exp_a    = '{9'h1FE, 9'h1FF, 9'h000};
      req_cnt  = 0;
      done_cnt = 0;
      burst_len_in = 9'd2;
      start_cycle(8'd1, 8'd1, 9'h1FE, 8'h40);
      for (int n = 1; n <= 16; n++) begin
        tick();
        if (n % 5 == 2) begin
          check($sformatf("burst_a_e%0d", n), a_out, exp_a[(n - 2) / 5]);
          check($sformatf("burst_d_e%0d", n), d_out, 8'h40 + 8'((n - 2) / 5));
        end
        if (n == 5 || n == 10) begin
          check($sformatf("burst_mid_e%0d", n), {writing, done, d_req}, 3'b101);
          d_in = (n == 5) ? 8'h41 : 8'h42;
        end
        if (n == 15) check("burst_final", {writing, done, d_req}, 3'b010);
        if (d_req) req_cnt++;
        if (done) done_cnt++;
      end
      check("burst_dreq_count", req_cnt, 2);
      check("burst_done_count", done_cnt, 1);
      burst_len_in = '0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_write_cycle.md
Name: sram_write_cycle

Overview:
- Transmit-side counterpart of the SRAM read sequencer: runs one timed SRAM write cycle per start pulse.
- Drives SRAM clock, chip enable, write enable, address and data bus, with programmable phase length and data hold.
- Sits between FPGA control logic (button/host start) and the level-translated SRAM pins.
- Shares pins with the read sequencer; top-level muxing selects by the `writing`/`reading` flags.

Parameters:
ADDR_W, 9, SRAM address width
DATA_W, 8, SRAM data width

Ports:
clk_in  in  1  internal clock, 100 MHz
reset_in  in  1  synchronous reset, active-low
start_in  in  1  single-tick start pulse
clk_factor  in  8  phase unit K in clk_in ticks; 0 treated as 1
hold_delay  in  8  data hold H after cen rises, in ticks; 0 treated as 1
a_in  in  ADDR_W  write address
d_in  in  DATA_W  write data
clk_out  out  1  SRAM clock
cen_out  out  1  SRAM chip enable, active-low
wen_out  out  1  SRAM write enable, active-low
a_out  out  ADDR_W  SRAM address
d_out  out  DATA_W  SRAM data
d_oe  out  1  data bus drive enable, high = FPGA drives
writing  out  1  high while a cycle is in progress
done  out  1  one-tick pulse at cycle end

Behaviour:
- Reset (reset_in low at a clk_in edge):
  - clk_out=1, cen_out=1, wen_out=1, a_out=0x1FF, d_out=0xFF, d_oe=0, writing=0, done=0.
  - State returns to IDLE and the counter clears.
  - Reset mid-cycle aborts on that edge with no done pulse.
- start_in is registered one stage (start_r).
- States: IDLE, ACTIVE (counter-driven phases), RELEASE.
- Acceptance: only in IDLE with start_r=1. start_r while not IDLE is ignored, not queued.
- Timeline. Acceptance edge is E1 (start_in high at E0); Kq=max(K,1), Hq=max(H,1); 16-bit counter, no overflow:
  - E1: a_in and d_in captured internally; clk_out=0; writing=1.
  - E2: cen_out=0, wen_out=0, a_out and d_out driven, d_oe=1.
  - E(1+2Kq): clk_out=1 (SRAM latches on this rising edge).
  - E(4Kq): cen_out=1, wen_out=1; d_out and d_oe held.
  - E(4Kq+Hq): d_oe=0, a_out=0x1FF, d_out=0xFF, writing=0, done=1 for one tick; state IDLE.
- clk_factor and hold_delay are sampled at E1 and held for the whole cycle.
- start_r high on the done edge is ignored; a new cycle needs start_r high at a later edge in IDLE.
- wen_out and cen_out always move together in this block.

Optional Feature:
- Macro SRAM_WRITE_BURST_EN adds ports burst_len_in (in, ADDR_W) and d_req (out, 1).
- burst_len_in is latched at E1. The cycle writes burst_len_in+1 words.
- On each non-final word's release edge:
  - d_req pulses one tick.
  - Address increments with wrap 0x1FF→0x000.
  - writing stays 1 and done does not pulse.
- The next word starts at the following edge as its E1, sampling d_in there.
- done pulses only after the final word.
- Without the macro: these ports are absent and the behaviour is single-word, as above.

Decomposition:
- Package sram_pkg: ADDR_W, DATA_W, ADDR_IDLE=0x1FF, DATA_IDLE=0xFF, state enum, and helper functions for clamped Kq/Hq. Shared with the read sequencer.
- One sub-module, sram_phase_counter: counter with clear/enable and compare outputs at 1, 2Kq, 4Kq-1 and 4Kq+Hq-1. Reused by the read sequencer.

Test Plan:
- Basic write: K=2, H=3, a=0x0A5, d=0x3C, start at E0 -> clk_out low E1, cen/wen low E2 with a_out=0x0A5 and d_out=0x3C, clk_out high E5, cen/wen high E8, d_oe low and done high E11, writing high for exactly 10 ticks.
- Clamp: K=0, H=0 -> same as K=1, H=1; done at E5.
- Start while busy: second start pulse at E4 of an 11-tick cycle -> ignored, only one done; a start 2 ticks after done -> new cycle.
- Reset mid-cycle: reset_in low at E6 -> all outputs at idle values on E6, no done; next start runs a normal cycle.
- Input change: a_in/d_in changed at E3 -> a_out/d_out keep the E1-captured values.
- Burst (SRAM_WRITE_BURST_EN): burst_len=2, a=0x1FE, K=1, H=1 -> three words at 0x1FE, 0x1FF, 0x000; two d_req pulses; one done after the third word.
